debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_sync_chain.sv | 26 ++
 rtl/debounce_sync.sv | 123 ++++++++++++
 tb/tb_debounce_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and parameter defaults for the debounce_sync block.
package debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_e;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1000;
  localparam int CNT_W_DEF           = 16;

endpackage

// File: rtl/debounce_sync_chain.sv
// Async-input synchronizer: SYNC_STAGES flops, no enable, no backpressure.
// dout reflects din SYNC_STAGES clk edges later.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronize + debounce a raw pin; q moves SYNC_STAGES+DEBOUNCE_CYCLES enabled edges after din, no backpressure.
// Optional registered rise/fall strobes when EDGE_DETECT_EN is defined.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  input  logic en,
  output logic q,
  output logic qn,
  output logic busy
`ifdef EDGE_DETECT_EN
  ,
  output logic rise,
  output logic fall
`endif
);

  localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debounce_sync: DEBOUNCE_CYCLES must be >= 1");
  end
  if (longint'(DEBOUNCE_CYCLES) >= CNT_SPAN) begin : g_bad_cnt_w
    $error("debounce_sync: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .din (din),
    .dout(s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    if (en) begin
      case (state_q)
        STABLE: begin
          if (s != q_q) begin
            // A one-cycle qualification window commits straight from STABLE.
            if (CNT_ONE == CNT_DONE) begin
              q_d = s;
            end else begin
              state_d = COUNTING;
              cnt_d   = CNT_ONE;
            end
          end
        end
        COUNTING: begin
          if (s == q_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q + CNT_ONE == CNT_DONE) begin
            q_d     = s;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  assign q    = q_q;
  assign qn   = ~q_q;
  assign busy = (state_q == COUNTING);

`ifdef EDGE_DETECT_EN
  logic rise_q, fall_q;

  // Strobes share the edge on which q itself updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= q_d & ~q_q;
      fall_q <= ~q_d & q_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench: main DUT (2 stages, 4 cycles) plus a 1-cycle debounce instance on the same pins.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic rstn, din, en;
  logic q, qn, busy;
  logic q1, qn1, busy1;
`ifdef EDGE_DETECT_EN
  logic rise, fall, rise1, fall1;
`endif

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4)
  ) u_dut (
    .clk (clk),
    .rstn(rstn),
    .din (din),
    .en  (en),
    .q   (q),
    .qn  (qn),
    .busy(busy)
`ifdef EDGE_DETECT_EN
    ,
    .rise(rise),
    .fall(fall)
`endif
  );

  debounce_sync #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(1),
    .CNT_W          (2)
  ) u_dut1 (
    .clk (clk),
    .rstn(rstn),
    .din (din),
    .en  (en),
    .q   (q1),
    .qn  (qn1),
    .busy(busy1)
`ifdef EDGE_DETECT_EN
    ,
    .rise(rise1),
    .fall(fall1)
`endif
  );

  typedef struct {
    string tag;
    int    edge_no;
    logic  q;
    logic  busy;
    logic  rise;
    logic  fall;
    logic  q1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      check($sformatf("%s e%0d q", mon_x.tag, mon_x.edge_no), q, mon_x.q);
      check($sformatf("%s e%0d qn", mon_x.tag, mon_x.edge_no), qn, ~mon_x.q);
      check($sformatf("%s e%0d busy", mon_x.tag, mon_x.edge_no), busy, mon_x.busy);
      check($sformatf("%s e%0d q1", mon_x.tag, mon_x.edge_no), q1, mon_x.q1);
      check($sformatf("%s e%0d qn1", mon_x.tag, mon_x.edge_no), qn1, ~mon_x.q1);
      check($sformatf("%s e%0d busy1", mon_x.tag, mon_x.edge_no), busy1, 1'b0);
`ifdef EDGE_DETECT_EN
      check($sformatf("%s e%0d rise", mon_x.tag, mon_x.edge_no), rise, mon_x.rise);
      check($sformatf("%s e%0d fall", mon_x.tag, mon_x.edge_no), fall, mon_x.fall);
`endif
    end
  end

  task automatic step(input string tag, input int e, input logic d, input logic en_v,
                      input logic xq, input logic xb, input logic xr, input logic xf,
                      input logic xq1);
    exp_t x;
    din = d;
    en  = en_v;
    @(posedge clk);
    x.tag     = tag;
    x.edge_no = e;
    x.q       = xq;
    x.busy    = xb;
    x.rise    = xr;
    x.fall    = xf;
    x.q1      = xq1;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, " q"}, q, 1'b0);
    check({tag, " qn"}, qn, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " q1"}, q1, 1'b0);
    check({tag, " qn1"}, qn1, 1'b1);
`ifdef EDGE_DETECT_EN
    check({tag, " rise"}, rise, 1'b0);
    check({tag, " fall"}, fall, 1'b0);
`endif
  endtask

  initial begin
    rstn = 1'b0;
    din  = 1'b0;
    en   = 1'b0;
    #12;
    reset_check("por");
    @(negedge clk);
    #1;
    rstn = 1'b1;

    for (int e = 1; e <= 4; e++) step("idle", e, 1'b0, 1'b1, 0, 0, 0, 0, 0);

    // Rising edge: busy after edges 3..5, q and rise at edge 6.
    for (int e = 1; e <= 8; e++)
      step("rise", e, 1'b1, 1'b1, e >= 6, e >= 3 && e <= 5, e == 6, 1'b0, e >= 3);

    for (int e = 1; e <= 8; e++)
      step("fall", e, 1'b0, 1'b1, e < 6, e >= 3 && e <= 5, 1'b0, e == 6, e < 3);

    // Three-cycle glitch is seen by the FSM at edges 3..5 and rejected at 6.
    for (int e = 1; e <= 8; e++)
      step("glitch", e, e <= 3, 1'b1, 1'b0, e >= 3 && e <= 5, 1'b0, 1'b0, e >= 3 && e <= 5);

    // en on odd edges only: qualifying edges 3,5,7,9.
    for (int e = 1; e <= 10; e++)
      step("en_tog", e, 1'b1, e % 2 == 1, e >= 9, e >= 3 && e <= 8, e == 9, 1'b0, e >= 3);

    din  = 1'b0;
    en   = 1'b1;
    rstn = 1'b0;
    #2;
    reset_check("rst_q1");
    @(negedge clk);
    #1;
    rstn = 1'b1;
    for (int e = 1; e <= 3; e++) step("idle2", e, 1'b0, 1'b1, 0, 0, 0, 0, 0);

    for (int e = 1; e <= 4; e++)
      step("abort", e, 1'b1, 1'b1, 1'b0, e >= 3, 1'b0, 1'b0, e >= 3);
    rstn = 1'b0;
    #2;
    reset_check("abort_rst");
    rstn = 1'b1;

    for (int e = 1; e <= 8; e++)
      step("post_rst", e, 1'b1, 1'b1, e >= 6, e >= 3 && e <= 5, e == 6, 1'b0, e >= 3);

    check("sb_drain", sb.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
